// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared types and constants for the Morse digit sequencer.
//                Holds the FSM state encoding, the ITU unit lengths of each
//                phase and a helper returning the last unit index of a phase.
//  Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    // Width of a Morse digit pattern (bit 4 sent first, 1 = dot, 0 = dash)
    localparam int CODE_W         = 5;

    // Phase lengths in Morse time units
    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;

    // Unit counter width; the longest phase is 3 units
    localparam int UNIT_CNT_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_EGAP = 2'd2,
        ST_CGAP = 2'd3
    } state_t;

    // Index of the final unit of a phase: the phase ends on the unit tick
    // seen while the unit counter holds this value.
    function automatic logic [UNIT_CNT_W-1:0] last_unit(input state_t st,
                                                        input logic   dot);
        int n;
        case (st)
            ST_ON:   n = dot ? DOT_UNITS : DASH_UNITS;
            ST_EGAP: n = ELEM_GAP_UNITS;
            ST_CGAP: n = CHAR_GAP_UNITS;
            default: n = 1;
        endcase
        return UNIT_CNT_W'(n - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_sequencer_if
//  Description : Handshake and output bundle of the Morse sequencer.
//                master : upstream keypad/codifier side (drives start, code)
//                slave  : the sequencer (drives busy, done, tone, is_dot,
//                         elem_idx)
//  Signals     : start, code[4:0], busy, done, tone, is_dot, elem_idx[2:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface morse_sequencer_if;
    import morse_pkg::*;

    logic              start;
    logic [CODE_W-1:0] code;
    logic              busy;
    logic              done;
    logic              tone;
    logic              is_dot;
    logic [2:0]        elem_idx;

    modport master (
        output start,
        output code,
        input  busy,
        input  done,
        input  tone,
        input  is_dot,
        input  elem_idx
    );

    modport slave (
        input  start,
        input  code,
        output busy,
        output done,
        output tone,
        output is_dot,
        output elem_idx
    );

endinterface
`default_nettype wire

// File: rtl/morse_unit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_unit_timer
//  Description : Prescaler producing one-cycle Morse unit ticks. Counts
//                0..UNIT_CYCLES-1 and ticks while holding the last value;
//                clr restarts the count at 0 so phases align to the FSM.
//  Ports       : clk, reset (async, active-high), clr (sync restart),
//                tick (one-cycle pulse at the end of each unit)
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 12500000,
    parameter int CNT_W       = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == C_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/morse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_sequencer
//  Description : Plays one 5-element Morse digit on a tone line with ITU
//                timing (dot 1, dash 3, element gap 1, character gap 3
//                units). Bit 4 of the code is sent first; 1 = dot, 0 = dash.
//  Ports       : clk, reset (async, active-high)
//                bus.start/code   - request from upstream, sampled on clk
//                bus.busy         - character in progress (incl. char gap)
//                bus.done         - one-cycle pulse when char gap completes
//                bus.tone         - high during element on-time
//                bus.is_dot       - type of current/last element
//                bus.elem_idx     - element in flight, 4 down to 0
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_sequencer #(
    parameter int UNIT_CYCLES = 12500000,
    parameter int CNT_W       = 24
) (
    input  logic               clk,
    input  logic               reset,
    morse_sequencer_if.slave   bus
);
    import morse_pkg::*;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CODE_W-1:0]       r_code;
    logic [CODE_W-1:0]       w_code_nxt;
    logic [UNIT_CNT_W-1:0]   r_unit_cnt;
    logic [UNIT_CNT_W-1:0]   w_unit_cnt_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    r_tone;
    logic                    w_tone_nxt;
    logic                    r_is_dot;
    logic                    w_is_dot_nxt;
    logic [2:0]              r_elem_idx;
    logic [2:0]              w_elem_idx_nxt;
    logic [2:0]              w_idx_dec;
    logic                    w_timer_clr;
    logic                    w_tick;

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (w_timer_clr),
        .tick  (w_tick)
    );

    // State and registered outputs; asynchronous reset drops tone at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_code     <= '0;
            r_unit_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tone     <= 1'b0;
            r_is_dot   <= 1'b0;
            r_elem_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_unit_cnt <= w_unit_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_tone     <= w_tone_nxt;
            r_is_dot   <= w_is_dot_nxt;
            r_elem_idx <= w_elem_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_unit_cnt_nxt = r_unit_cnt;
        w_is_dot_nxt   = r_is_dot;
        w_elem_idx_nxt = r_elem_idx;
        w_done_nxt     = 1'b0;
        w_timer_clr    = 1'b0;
        w_idx_dec      = r_elem_idx - 3'd1;

        case (r_state)
            ST_IDLE: begin
                // Hold the prescaler at 0 so the first unit starts exactly
                // at the accepting edge.
                w_timer_clr    = 1'b1;
                w_unit_cnt_nxt = '0;
                if (bus.start) begin
                    w_code_nxt     = bus.code;
                    w_elem_idx_nxt = 3'(CODE_W - 1);
                    w_is_dot_nxt   = bus.code[CODE_W-1];
                    w_state_nxt    = ST_ON;
                end
            end

            default: begin
                if (w_tick) begin
                    if (r_unit_cnt == last_unit(r_state, r_is_dot)) begin
                        w_timer_clr    = 1'b1;
                        w_unit_cnt_nxt = '0;
                        case (r_state)
                            ST_ON: begin
                                w_state_nxt = (r_elem_idx == 3'd0) ? ST_CGAP
                                                                   : ST_EGAP;
                            end
                            ST_EGAP: begin
                                // elem_idx only moves here, never from 0
                                w_elem_idx_nxt = w_idx_dec;
                                w_is_dot_nxt   = r_code[w_idx_dec];
                                w_state_nxt    = ST_ON;
                            end
                            ST_CGAP: begin
                                w_state_nxt = ST_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                            default: begin
                                w_state_nxt = ST_IDLE;
                            end
                        endcase
                    end else begin
                        w_unit_cnt_nxt = r_unit_cnt + UNIT_CNT_W'(1);
                    end
                end
            end
        endcase

        // Output registers follow the next state so they change on the
        // same edge as the state itself.
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_tone_nxt = (w_state_nxt == ST_ON);
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.tone     = r_tone;
    assign bus.is_dot   = r_is_dot;
    assign bus.elem_idx = r_elem_idx;

endmodule
`default_nettype wire

// File: tb/tb_morse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_sequencer
//  Description : Self-checking bench for morse_sequencer. Two instances
//                (UNIT_CYCLES=4 and UNIT_CYCLES=2) share the stimulus; a
//                scoreboard of expected tone runs and busy lengths is filled
//                when a start is driven and drained as the DUT plays.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_sequencer;
    import morse_pkg::*;

    typedef struct {
        logic       lvl;
        int         len;
        logic       dot;
        logic [2:0] idx;
    } seg_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_r;
    logic [4:0] code_r;
    logic       sel;

    int n_vec = 0;
    int n_bad = 0;

    seg_t seg_q[$];
    int   busy_q[$];

    always #5 clk = ~clk;

    morse_sequencer_if bus4();
    morse_sequencer_if bus2();

    assign bus4.start = start_r & ~sel;
    assign bus4.code  = code_r;
    assign bus2.start = start_r & sel;
    assign bus2.code  = code_r;

    morse_sequencer #(.UNIT_CYCLES(4), .CNT_W(3)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    morse_sequencer #(.UNIT_CYCLES(2), .CNT_W(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    logic       w_busy, w_done, w_tone, w_dot;
    logic [2:0] w_idx;
    assign w_busy = sel ? bus2.busy     : bus4.busy;
    assign w_done = sel ? bus2.done     : bus4.done;
    assign w_tone = sel ? bus2.tone     : bus4.tone;
    assign w_dot  = sel ? bus2.is_dot   : bus4.is_dot;
    assign w_idx  = sel ? bus2.elem_idx : bus4.elem_idx;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected behaviour of one character: for each element an on-run of
    // 1 or 3 units, then a 1-unit gap, or a 3-unit gap after the last one.
    // During a gap is_dot/elem_idx still show the element just sent.
    function automatic void push_char(input logic [4:0] c, input int u);
        seg_t s;
        int   on_units;
        on_units = 0;
        for (int i = 4; i >= 0; i--) begin
            s.lvl = 1'b1;
            s.len = (c[i] ? 1 : 3) * u;
            s.dot = c[i];
            s.idx = 3'(i);
            seg_q.push_back(s);
            on_units += c[i] ? 1 : 3;
            s.lvl = 1'b0;
            s.len = ((i == 0) ? 3 : 1) * u;
            seg_q.push_back(s);
        end
        busy_q.push_back((on_units + 4 + 3) * u);
    endfunction

    // Plays one character (optionally a second one started in the done
    // cycle) and checks it run by run against the scoreboard.
    task automatic play(input logic [4:0] c, input logic use2, input int hold,
                        input logic chg, input logic b2b, input logic [4:0] c2);
        int   u, cyc, busy_len, done_cnt, chars, exp_chars, start_left;
        logic prev_busy, start_pending, run_open;
        seg_t run, exp_s;
        int   exp_busy;

        u          = use2 ? 2 : 4;
        cyc        = 0;
        busy_len   = 0;
        done_cnt   = 0;
        chars      = 0;
        exp_chars  = b2b ? 2 : 1;
        prev_busy  = 1'b0;
        run_open   = 1'b0;
        run        = '{1'b0, 0, 1'b0, 3'd0};
        sel        = use2;
        seg_q.delete();
        busy_q.delete();
        push_char(c, u);
        code_r        = c;
        start_r       = 1'b1;
        start_left    = (hold > 0) ? hold : 1;
        start_pending = 1'b1;

        while (chars < exp_chars && cyc < 400) begin
            step();
            cyc++;
            if (start_left > 0) start_left--;
            if (start_left == 0) start_r = 1'b0;
            if (chg && cyc == 10) code_r = ~c;

            if (start_pending) begin
                n_vec++;
                if (w_busy !== 1'b1 || w_tone !== 1'b1) begin
                    n_bad++;
                    $display("FAIL start_latency: busy=%b tone=%b, expected busy=1 tone=1",
                             w_busy, w_tone);
                end
                start_pending = 1'b0;
            end

            if (run_open && (!w_busy || w_tone !== run.lvl)) begin
                n_vec++;
                if (seg_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL tone_run: extra run lvl=%b len=%0d, expected none",
                             run.lvl, run.len);
                end else begin
                    exp_s = seg_q.pop_front();
                    if (run.lvl !== exp_s.lvl || run.len != exp_s.len ||
                        run.dot !== exp_s.dot || run.idx !== exp_s.idx) begin
                        n_bad++;
                        $display("FAIL tone_run: lvl=%b len=%0d dot=%b idx=%0d, expected lvl=%b len=%0d dot=%b idx=%0d",
                                 run.lvl, run.len, run.dot, run.idx,
                                 exp_s.lvl, exp_s.len, exp_s.dot, exp_s.idx);
                    end
                end
                run_open = 1'b0;
            end

            if (w_busy) begin
                busy_len++;
                if (!run_open) begin
                    run      = '{w_tone, 1, w_dot, w_idx};
                    run_open = 1'b1;
                end else begin
                    run.len++;
                end
            end

            if (w_done) done_cnt++;

            if (prev_busy && !w_busy) begin
                n_vec++;
                if (w_done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL done_at_busy_fall: done=%b, expected 1", w_done);
                end
                exp_busy = (busy_q.size() > 0) ? busy_q.pop_front() : -1;
                n_vec++;
                if (busy_len != exp_busy) begin
                    n_bad++;
                    $display("FAIL busy_length: got %0d cycles, expected %0d",
                             busy_len, exp_busy);
                end
                busy_len = 0;
                chars++;
                if (b2b && chars == 1) begin
                    push_char(c2, u);
                    code_r        = c2;
                    start_r       = 1'b1;
                    start_left    = 1;
                    start_pending = 1'b1;
                end
            end
            prev_busy = w_busy;
        end

        n_vec++;
        if (chars < exp_chars) begin
            n_bad++;
            $display("FAIL char_timeout: finished %0d chars, expected %0d", chars, exp_chars);
        end
        start_r = 1'b0;

        // Quiet tail: nothing may restart and no stray done may appear
        for (int i = 0; i < 8; i++) begin
            step();
            if (w_done) done_cnt++;
            n_vec++;
            if (w_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_after_char: busy=%b, expected 0", w_busy);
            end
        end
        n_vec++;
        if (done_cnt != exp_chars) begin
            n_bad++;
            $display("FAIL done_count: got %0d, expected %0d", done_cnt, exp_chars);
        end
        n_vec++;
        if (seg_q.size() != 0) begin
            n_bad++;
            $display("FAIL runs_left: %0d runs not seen, expected 0", seg_q.size());
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start_r = 1'b0;
        code_r  = 5'b0;
        sel     = 1'b0;
        step();
        step();
        n_vec++;
        if ({bus4.busy, bus4.done, bus4.tone, bus4.is_dot, bus4.elem_idx} !== 7'b0 ||
            {bus2.busy, bus2.done, bus2.tone, bus2.is_dot, bus2.elem_idx} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_state: u4=%b%b%b%b%03b u2=%b%b%b%b%03b, expected all 0",
                     bus4.busy, bus4.done, bus4.tone, bus4.is_dot, bus4.elem_idx,
                     bus2.busy, bus2.done, bus2.tone, bus2.is_dot, bus2.elem_idx);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_dots();
        play(5'b11111, 1'b0, 0, 1'b0, 1'b0, 5'b0);
    endtask

    task automatic test_dashes();
        play(5'b00000, 1'b0, 0, 1'b0, 1'b0, 5'b0);
    endtask

    task automatic test_hold_and_code_change();
        play(5'b10000, 1'b0, 30, 1'b1, 1'b0, 5'b0);
    endtask

    task automatic test_back_to_back();
        play(5'b11111, 1'b0, 0, 1'b0, 1'b1, 5'b01111);
    endtask

    task automatic test_unit2_boundary();
        play(5'b11100, 1'b1, 0, 1'b0, 1'b0, 5'b0);
    endtask

    task automatic test_reset_midchar();
        sel     = 1'b0;
        code_r  = 5'b11000;
        start_r = 1'b1;
        step();
        start_r = 1'b0;
        // Second element (a dot) is on for samples 9..12 after acceptance
        for (int i = 1; i < 10; i++) step();
        n_vec++;
        if (w_tone !== 1'b1 || w_idx !== 3'd3) begin
            n_bad++;
            $display("FAIL second_element_on: tone=%b idx=%0d, expected tone=1 idx=3",
                     w_tone, w_idx);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (w_tone !== 1'b0 || w_busy !== 1'b0 || w_done !== 1'b0 ||
            w_dot !== 1'b0 || w_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL async_reset: tone=%b busy=%b done=%b dot=%b idx=%0d, expected all 0",
                     w_tone, w_busy, w_done, w_dot, w_idx);
        end
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_vec++;
            if (w_busy !== 1'b0 || w_done !== 1'b0 || w_tone !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_after_reset: busy=%b done=%b tone=%b, expected 0 0 0",
                         w_busy, w_done, w_tone);
            end
        end
        play(5'b11000, 1'b0, 0, 1'b0, 1'b0, 5'b0);
    endtask

    initial begin
        test_reset();
        test_dots();
        test_dashes();
        test_hold_and_code_change();
        test_back_to_back();
        test_reset_midchar();
        test_unit2_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
